// File: rtl/bank_addr_xbar_pipe.sv
// Registered N-bank address crossbar: lane map register, 2-entry output FIFO, accepted-beat counter.
// Optional XBAR_PERM_CHECK_EN rejects non-permutation maps and reports them on cfg_err.
module bank_addr_xbar_pipe #(
   parameter int N_BANK = 8,
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_we,
   input  logic [N_BANK*$clog2(N_BANK)-1:0] cfg_sel,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_BANK*ADDR_W-1:0]     in_addr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N_BANK*ADDR_W-1:0]     out_addr,
   output logic [CNT_W-1:0]             beat_cnt
`ifdef XBAR_PERM_CHECK_EN
   ,
   output logic                         cfg_err
`endif
);

   localparam int SEL_W = $clog2(N_BANK);
   localparam int AW    = N_BANK * ADDR_W;
   localparam int SW    = N_BANK * SEL_W;

   function automatic logic [SW-1:0] ident_map();
      logic [SW-1:0] m;
      m = '0;
      for (int i = 0; i < N_BANK; i++) m[i*SEL_W +: SEL_W] = SEL_W'(i);
      return m;
   endfunction

   localparam logic [SW-1:0] SEL_RST = ident_map();

   logic [SW-1:0]    sel_q, sel_d;
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [AW-1:0]    routed;
   logic             push, pop, map_ok;

   assign in_ready  = (cnt_q < 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign out_addr  = head_q;
   assign beat_cnt  = beat_cnt_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      routed = '0;
      for (int i = 0; i < N_BANK; i++)
         routed[i*ADDR_W +: ADDR_W] = in_addr[int'(sel_q[i*SEL_W +: SEL_W])*ADDR_W +: ADDR_W];
   end

`ifdef XBAR_PERM_CHECK_EN
   logic cfg_err_q, cfg_err_d;
   logic dup;

   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < N_BANK; i++)
         for (int j = i + 1; j < N_BANK; j++)
            if (cfg_sel[i*SEL_W +: SEL_W] == cfg_sel[j*SEL_W +: SEL_W]) dup = 1'b1;
   end

   assign map_ok    = !dup;
   assign cfg_err_d = cfg_we && dup;
   assign cfg_err   = cfg_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_err_q <= 1'b0;
      else        cfg_err_q <= cfg_err_d;
   end
`else
   assign map_ok = 1'b1;
`endif

   always_comb begin
      sel_d      = sel_q;
      head_d     = head_q;
      tail_d     = tail_q;
      cnt_d      = cnt_q;
      beat_cnt_d = beat_cnt_q;
      if (cfg_we && map_ok) sel_d = cfg_sel;
      if (push) beat_cnt_d = beat_cnt_q + CNT_W'(1);
      case (cnt_q)
         2'd0: begin
            if (push) begin
               head_d = routed;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            // Simultaneous push/pop: new beat replaces the departing head.
            case ({push, pop})
               2'b11:   head_d = routed;
               2'b10: begin
                  tail_d = routed;
                  cnt_d  = 2'd2;
               end
               2'b01:   cnt_d = 2'd0;
               default: ;
            endcase
         end
         default: begin
            if (pop) begin
               head_d = tail_q;
               cnt_d  = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q      <= SEL_RST;
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= 2'd0;
         beat_cnt_q <= '0;
      end else begin
         sel_q      <= sel_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule
